// File: rtl/spi_slave_io.sv
// SPI mode-0 target on the 6800-style peripheral bus: one-byte RX/TX holding
// registers, overrun/underrun flags, level interrupt.
module spi_slave_io #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  DUMMY_RESET = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] AD,
  input  logic [7:0] DI,
  output logic [7:0] DO,
  input  logic       rw,
  input  logic       cs,
  output logic       irq,
  input  logic       ssn,
  input  logic       sck,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe
);

  logic [SYNC_STAGES-1:0] sck_sync, ssn_sync, mosi_sync;
  logic       sck_s, ssn_s, mosi_s;
  logic       sck_d, ssn_d;

  logic [7:0] rx_data, rx_shift, tx_hold, tx_shift, dummy;
  logic       rx_full, tx_full, ovr, udr;
  logic       ctrl_en, txie, rxie;
  logic [2:0] bit_cnt;

  logic       active, ssn_fall, sck_rise, sck_fall, byte_done, tx_load;
  logic       data_rd, data_wr, stat_wr, ctrl_wr, dummy_wr;
  logic [7:0] rx_next;

  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign ssn_s  = ssn_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign active    = ctrl_en & ~ssn_s;
  assign ssn_fall  = active & ssn_d;
  assign sck_rise  = active & ~sck_d & sck_s;
  assign sck_fall  = active & sck_d & ~sck_s;
  assign byte_done = sck_rise & (bit_cnt == 3'd7);
  assign tx_load   = ssn_fall | byte_done;
  assign rx_next   = {rx_shift[6:0], mosi_s};

  assign data_rd  = cs &  rw & (AD == 2'd0);
  assign data_wr  = cs & ~rw & (AD == 2'd0);
  assign stat_wr  = cs & ~rw & (AD == 2'd1);
  assign ctrl_wr  = cs & ~rw & (AD == 2'd2);
  assign dummy_wr = cs & ~rw & (AD == 2'd3);

  assign miso    = tx_shift[7];
  assign miso_oe = active;

  always_comb begin
    DO = '0;
    case (AD)
      2'd0: DO = rx_data;
      2'd1: DO = {irq, 2'b00, ~ssn_s, udr, ovr, ~tx_full, rx_full};
      2'd2: DO = {ctrl_en, 5'b00000, txie, rxie};
      2'd3: DO = dummy;
      default: DO = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sck_sync  <= '0;
      ssn_sync  <= '1;
      mosi_sync <= '0;
      sck_d     <= 1'b0;
      ssn_d     <= 1'b1;
      rx_data   <= '0;
      rx_shift  <= '0;
      rx_full   <= 1'b0;
      tx_hold   <= '0;
      tx_full   <= 1'b0;
      tx_shift  <= '0;
      ovr       <= 1'b0;
      udr       <= 1'b0;
      ctrl_en   <= 1'b0;
      txie      <= 1'b0;
      rxie      <= 1'b0;
      dummy     <= DUMMY_RESET;
      bit_cnt   <= '0;
      irq       <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
      ssn_sync  <= {ssn_sync[SYNC_STAGES-2:0], ssn};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sck_d     <= sck_s;
      ssn_d     <= ssn_s;

      // Clears are applied first so a same-cycle set from the SPI side wins.
      if (stat_wr) begin
        if (DI[2]) ovr <= 1'b0;
        if (DI[3]) udr <= 1'b0;
      end
      if (data_rd) rx_full <= 1'b0;

      if (!active || ssn_fall) begin
        bit_cnt <= '0;
      end else if (sck_rise) begin
        rx_shift <= rx_next;
        bit_cnt  <= bit_cnt + 3'd1;
        // A read in this cycle frees the holding register for the new byte.
        if (byte_done) begin
          if (!rx_full || data_rd) begin
            rx_data <= rx_next;
            rx_full <= 1'b1;
          end else begin
            ovr <= 1'b1;
          end
        end
      end else if (sck_fall && bit_cnt != 3'd0) begin
        tx_shift <= {tx_shift[6:0], 1'b0};
      end

      if (tx_load) begin
        if (tx_full) begin
          tx_shift <= tx_hold;
          tx_full  <= 1'b0;
        end else begin
          tx_shift <= dummy;
          udr      <= 1'b1;
        end
      end
      if (data_wr) begin
        tx_hold <= DI;
        tx_full <= 1'b1;
      end

      if (ctrl_wr) begin
        ctrl_en <= DI[7];
        txie    <= DI[1];
        rxie    <= DI[0];
      end
      if (dummy_wr) dummy <= DI;

      irq <= (rxie & rx_full) | (txie & ctrl_en & ~tx_full);
    end
  end

endmodule

// File: tb/tb_spi_slave_io.sv
// Bench for spi_slave_io: CPU bus tasks plus a clk/8 SPI master, with
// scoreboard queues for expected miso bytes and expected received bytes.
module tb_spi_slave_io;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] AD = '0;
  logic [7:0] DI = '0;
  logic [7:0] DO;
  logic       rw = 1'b1;
  logic       cs = 1'b0;
  logic       irq;
  logic       ssn = 1'b1;
  logic       sck = 1'b0;
  logic       mosi = 1'b0;
  logic       miso;
  logic       miso_oe;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [7:0] miso_q[$];
  logic [7:0] rx_q[$];

  spi_slave_io #(.SYNC_STAGES(2), .DUMMY_RESET(8'hFF)) dut (
    .clk(clk), .rst(rst), .AD(AD), .DI(DI), .DO(DO), .rw(rw), .cs(cs),
    .irq(irq), .ssn(ssn), .sck(sck), .mosi(mosi), .miso(miso), .miso_oe(miso_oe)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // All bus tasks start and end on a falling clk edge.
  task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
    cs = 1'b1; rw = 1'b0; AD = a; DI = d;
    @(negedge clk);
    cs = 1'b0; rw = 1'b1;
  endtask

  task automatic cpu_read(input logic [1:0] a, output logic [7:0] d);
    cs = 1'b1; rw = 1'b1; AD = a;
    #1 d = DO;
    @(negedge clk);
    cs = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [1:0] a, input logic [7:0] exp);
    logic [7:0] d;
    cpu_read(a, d);
    chk(tag, d, exp);
  endtask

  task automatic read_rx(input string tag);
    logic [7:0] d;
    logic [7:0] e;
    cpu_read(2'd0, d);
    if (rx_q.size() == 0) begin
      chk({tag, "_rxq_empty"}, 8'h01, 8'h00);
    end else begin
      e = rx_q.pop_front();
      chk(tag, d, e);
    end
  endtask

  task automatic frame_open(input string tag, input logic exp_oe);
    ssn = 1'b0;
    repeat (6) @(negedge clk);
    chk({tag, "_oe"}, {7'b0, miso_oe}, {7'b0, exp_oe});
  endtask

  task automatic frame_close;
    repeat (4) @(negedge clk);
    ssn = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  // Half-period of 4 clks; miso is sampled as sck rises, like a mode-0 master.
  task automatic xfer(input string tag, input logic [7:0] tx, input int unsigned nbits,
                      input bit chk_miso);
    logic [7:0] got;
    logic [7:0] e;
    got = '0;
    for (int unsigned i = 0; i < nbits; i++) begin
      mosi = tx[7-i];
      repeat (4) @(negedge clk);
      got = {got[6:0], miso};
      sck = 1'b1;
      repeat (4) @(negedge clk);
      sck = 1'b0;
    end
    if (chk_miso) begin
      if (miso_q.size() == 0) begin
        chk({tag, "_misoq_empty"}, 8'h01, 8'h00);
      end else begin
        e = miso_q.pop_front();
        chk({tag, "_miso"}, got, e);
      end
    end
  endtask

  task automatic send_byte(input string tag, input logic [7:0] tx, input logic [7:0] exp_miso);
    miso_q.push_back(exp_miso);
    rx_q.push_back(tx);
    xfer(tag, tx, 8, 1'b1);
  endtask

  initial begin
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    chk("rst_irq", {7'b0, irq}, 8'h00);
    chk("rst_oe", {7'b0, miso_oe}, 8'h00);
    chk("rst_miso", {7'b0, miso}, 8'h00);
    read_chk("rst_status", 2'd1, 8'h02);
    read_chk("rst_dummy", 2'd3, 8'hFF);
    read_chk("rst_ctrl", 2'd2, 8'h00);

    // Disabled: SPI traffic is ignored entirely.
    frame_open("dis", 1'b0);
    xfer("dis", 8'h99, 8, 1'b0);
    frame_close();
    read_chk("dis_status", 2'd1, 8'h02);

    // Basic transfer; end-of-byte reload with nothing queued flags underrun.
    cpu_write(2'd2, 8'h80);
    read_chk("ctrl_en", 2'd2, 8'h80);
    cpu_write(2'd0, 8'hA5);
    read_chk("txfull_status", 2'd1, 8'h00);
    frame_open("basic", 1'b1);
    send_byte("basic", 8'h3C, 8'hA5);
    frame_close();
    read_chk("basic_status", 2'd1, 8'h0B);
    read_rx("basic_rx");
    read_chk("basic_status_rd", 2'd1, 8'h0A);
    cpu_write(2'd1, 8'h08);
    read_chk("basic_status_clr", 2'd1, 8'h02);

    // Underrun with a custom fill byte.
    cpu_write(2'd3, 8'h5A);
    read_chk("dummy_wr", 2'd3, 8'h5A);
    frame_open("udr", 1'b1);
    send_byte("udr", 8'h00, 8'h5A);
    frame_close();
    read_chk("udr_status", 2'd1, 8'h0B);
    cpu_write(2'd1, 8'h08);
    read_chk("udr_clr", 2'd1, 8'h03);
    read_rx("udr_rx");

    // Overrun: second byte dropped, first kept.
    frame_open("ovr", 1'b1);
    send_byte("ovr0", 8'h11, 8'h5A);
    miso_q.push_back(8'h5A);
    xfer("ovr1", 8'h22, 8, 1'b1);
    frame_close();
    read_chk("ovr_status", 2'd1, 8'h0F);
    read_rx("ovr_rx");
    cpu_write(2'd1, 8'h0C);
    read_chk("ovr_clr", 2'd1, 8'h02);

    // Abort after 4 bits, then a clean byte.
    frame_open("abort_part", 1'b1);
    xfer("abort_part", 8'hF0, 4, 1'b0);
    frame_close();
    chk("abort_oe_off", {7'b0, miso_oe}, 8'h00);
    frame_open("abort", 1'b1);
    send_byte("abort", 8'hC3, 8'h5A);
    frame_close();
    read_chk("abort_status", 2'd1, 8'h0B);
    read_rx("abort_rx");
    cpu_write(2'd1, 8'h08);

    // RX interrupt and its 1-clk release after a DATA read.
    cpu_write(2'd2, 8'h81);
    chk("irq_idle", {7'b0, irq}, 8'h00);
    frame_open("irq", 1'b1);
    send_byte("irq", 8'h77, 8'h5A);
    frame_close();
    chk("irq_rx", {7'b0, irq}, 8'h01);
    read_chk("irq_status", 2'd1, 8'h8B);
    read_rx("irq_rx_data");
    chk("irq_hold", {7'b0, irq}, 8'h01);
    @(negedge clk);
    chk("irq_clear", {7'b0, irq}, 8'h00);
    cpu_write(2'd1, 8'h08);

    // TX interrupt: asserts when TX holding is empty, drops once it is filled.
    cpu_write(2'd2, 8'h82);
    chk("txirq_lat", {7'b0, irq}, 8'h00);
    @(negedge clk);
    chk("txirq_set", {7'b0, irq}, 8'h01);
    cpu_write(2'd0, 8'h3E);
    chk("txirq_hold", {7'b0, irq}, 8'h01);
    @(negedge clk);
    chk("txirq_clr", {7'b0, irq}, 8'h00);
    read_chk("final_status", 2'd1, 8'h00);

    chk("miso_q_drained", 8'(miso_q.size()), 8'h00);
    chk("rx_q_drained", 8'(rx_q.size()), 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
